// File: rtl/serial_twos_invert.sv
// Bit-serial two's-complement negator: LSB-first operand in, negated bit out in the same cycle.
// Copies bits up to and including the first 1 of a word, then inverts every later bit.
`timescale 1ns/1ps

module serial_twos_invert #(
    parameter int FRAME_LEN = 0
) (
    input  logic t_clock,
    input  logic r,
    input  logic i,
    output logic y
);

    typedef enum logic {
        COPY   = 1'b0,
        INVERT = 1'b1
    } state_t;

    state_t state_r;
    logic   wrap_s;

    generate
        if (FRAME_LEN > 0) begin : g_frame
            localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
            localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

            logic [CNT_W-1:0] cnt_r;

            // Position of the current bit within its fixed-length word.
            always_ff @(posedge t_clock) begin
                if (r) begin
                    cnt_r <= {CNT_W{1'b0}};
                end else if (cnt_r == LAST) begin
                    cnt_r <= {CNT_W{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end

            assign wrap_s = (cnt_r == LAST);
        end else begin : g_noframe
            assign wrap_s = 1'b0;
        end
    endgenerate

    // Copy/invert state; a frame wrap restarts the word even if the last bit was a 1.
    always_ff @(posedge t_clock) begin
        if (r) begin
            state_r <= COPY;
        end else if (wrap_s) begin
            state_r <= COPY;
        end else begin
            case (state_r)
                COPY:    state_r <= i ? INVERT : COPY;
                INVERT:  state_r <= INVERT;
                default: state_r <= COPY;
            endcase
        end
    end

    // Same-cycle output so the sink sees the negated bit with zero latency.
    assign y = i ^ (state_r == INVERT);

endmodule

// File: tb/tb_serial_twos_invert.sv
// Scoreboard bench for serial_twos_invert: unframed instance and a FRAME_LEN=4 instance.
`timescale 1ns/1ps

module tb_serial_twos_invert;

    logic t_clock;
    logic r0, i0, y0;
    logic r4, i4, y4;

    typedef struct {
        bit sel;
        bit exp;
        int tag;
    } exp_t;

    exp_t exp_q[$];
    int   applied;
    int   miscompares;
    int   tag_n;

    serial_twos_invert #(.FRAME_LEN(0)) dut0 (
        .t_clock (t_clock),
        .r       (r0),
        .i       (i0),
        .y       (y0)
    );

    serial_twos_invert #(.FRAME_LEN(4)) dut4 (
        .t_clock (t_clock),
        .r       (r4),
        .i       (i4),
        .y       (y4)
    );

    // 40 ns period, rising edges at 20 + 40k ns.
    initial begin
        t_clock = 1'b0;
        forever #20 t_clock = ~t_clock;
    end

    // Drive one bit to the selected instance after the falling edge; queue the expected y.
    task automatic step(input bit sel, input bit rr, input bit ii, input bit chk, input bit ex);
        exp_t e;
        @(negedge t_clock);
        #1;
        if (sel) begin
            r4 = rr;
            i4 = ii;
        end else begin
            r0 = rr;
            i0 = ii;
        end
        if (chk) begin
            e.sel = sel;
            e.exp = ex;
            e.tag = tag_n;
            tag_n++;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: y is sampled mid-low-phase, well away from the rising edge.
    initial begin
        exp_t e;
        logic act;
        forever begin
            @(negedge t_clock);
            #10;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = e.sel ? y4 : y0;
                applied++;
                if (act !== e.exp) begin
                    miscompares++;
                    $display("FAIL vec%0d dut_frame%0d: y=%b expected %b", e.tag, e.sel ? 4 : 0, act, e.exp);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        applied     = 0;
        miscompares = 0;
        tag_n       = 0;
        r0 = 1'b1; i0 = 1'b0;
        r4 = 1'b1; i4 = 1'b0;

        // Reset state: while r=1 and seen=0, y mirrors i.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // 4 (0,0,1,0) -> 12 (0,0,1,1)
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // 13 (1,0,1,1) -> 3 (1,1,0,0); first bit checked before its clock edge.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Eight zeros stay zero, then first 1 copied, following 0 inverted.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Most negative 4-bit word (0,0,0,1) maps to itself.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Mid-word reset with i=1: y still uses old seen that cycle, then a fresh word.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Timed sequence: reset twice, i=1 twice, then i=0.
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // FRAME_LEN=4: automatic restart at every fourth bit.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        // Wrap beats i=1 on the last bit: 1,1,1,1 -> 1,0,0,0 then 1,0,0,0 -> 1,1,1,1.
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        // Mid-frame reset realigns the frame counter.
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

        // Let the monitor drain the scoreboard, within a bounded number of cycles.
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge t_clock);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
